// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - state codes, side encoding and default phase durations for the lock scheduler
package lock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t EQ_S  = 3'd1;
    localparam state_t EQ_W  = 3'd2;
    localparam state_t ENT_S = 3'd3;
    localparam state_t ENT_W = 3'd4;
    localparam state_t XF_S  = 3'd5;
    localparam state_t XF_W  = 3'd6;
    localparam state_t EXIT  = 3'd7;

    localparam logic SIDE_LO = 1'b0;
    localparam logic SIDE_HI = 1'b1;

    localparam int ENTRY_SEC_DEF = 300;
    localparam int FILL_SEC_DEF  = 420;
    localparam int DRAIN_SEC_DEF = 480;

    function automatic logic is_wait_state(input state_t s);
        return (s == EQ_W) || (s == ENT_W) || (s == XF_W);
    endfunction

endpackage

// File: rtl/lock_req_arbiter.sv
// rtl/lock_req_arbiter.sv - latches low/high transit requests and picks the side to serve
module lock_req_arbiter
    import lock_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_lo,
    input  logic req_hi,
    input  logic take,
    output logic grant_valid,
    output logic grant_side
);

    logic pending_lo;
    logic pending_hi;
    logic last_grant;

    // Contention alternates so neither side can starve the other.
    always_comb begin
        grant_valid = pending_lo | pending_hi;
        grant_side  = (pending_lo && pending_hi) ? ~last_grant : pending_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_lo <= 1'b0;
            pending_hi <= 1'b0;
            last_grant <= SIDE_LO;
        end else begin
            pending_lo <= req_lo | (pending_lo & ~(take & (grant_side == SIDE_LO)));
            pending_hi <= req_hi | (pending_hi & ~(take & (grant_side == SIDE_HI)));
            if (take) begin
                last_grant <= grant_side;
            end
        end
    end

endmodule

// File: rtl/lock_transit_scheduler.sv
// rtl/lock_transit_scheduler.sv - two-gate lock transit sequencer; LOCK_TRANSIT_COUNT_EN adds transit_count
module lock_transit_scheduler
    import lock_pkg::*;
#(
    parameter int FILL_SEC  = FILL_SEC_DEF,
    parameter int DRAIN_SEC = DRAIN_SEC_DEF,
    parameter int ENTRY_SEC = ENTRY_SEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_lo,
    input  logic        req_hi,
    input  logic        boat_in,
    input  logic        boat_out,
    input  logic        timer_done,
    output logic        timer_start,
    output logic [9:0]  timer_seconds,
    output logic        gate_lo_open,
    output logic        gate_hi_open,
    output logic        fill_valve,
    output logic        drain_valve,
    output logic        grant_hi,
`ifdef LOCK_TRANSIT_COUNT_EN
    output logic [15:0] transit_count,
`endif
    output logic        busy
);

    localparam logic [9:0] FILL_LD  = 10'(FILL_SEC);
    localparam logic [9:0] DRAIN_LD = 10'(DRAIN_SEC);
    localparam logic [9:0] ENTRY_LD = 10'(ENTRY_SEC);

    state_t state;
    logic   grant_r;
    logic   level_hi;
    logic   level_known;
    logic   armed;
    logic   take;
    logic   done_ok;
    logic   grant_valid;
    logic   grant_side;
    logic   in_eq;
    logic   in_ent;
    logic   in_xf;

    lock_req_arbiter u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req_lo      (req_lo),
        .req_hi      (req_hi),
        .take        (take),
        .grant_valid (grant_valid),
        .grant_side  (grant_side)
    );

    // The timer still shows the previous expiry during the first wait cycle.
    assign done_ok = armed & timer_done;
    assign take    = (state == IDLE) && grant_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant_r     <= SIDE_LO;
            level_hi    <= 1'b0;
            level_known <= 1'b0;
            armed       <= 1'b0;
        end else begin
            armed <= is_wait_state(state);
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_r <= grant_side;
                        state   <= (!level_known || (level_hi != grant_side)) ? EQ_S : ENT_S;
                    end
                end
                EQ_S:  state <= EQ_W;
                EQ_W: begin
                    if (done_ok) begin
                        level_hi    <= grant_r;
                        level_known <= 1'b1;
                        state       <= ENT_S;
                    end
                end
                ENT_S: state <= ENT_W;
                ENT_W: begin
                    if (boat_in) begin
                        state <= XF_S;
                    end else if (done_ok) begin
                        state <= IDLE;
                    end
                end
                XF_S:  state <= XF_W;
                XF_W: begin
                    if (done_ok) begin
                        level_hi <= ~level_hi;
                        state    <= EXIT;
                    end
                end
                EXIT: begin
                    if (boat_out) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_eq  = (state == EQ_S)  || (state == EQ_W);
        in_ent = (state == ENT_S) || (state == ENT_W);
        in_xf  = (state == XF_S)  || (state == XF_W);

        timer_start   = (state == EQ_S) || (state == ENT_S) || (state == XF_S);
        timer_seconds = 10'd0;
        case (state)
            EQ_S:    timer_seconds = (grant_r == SIDE_HI) ? FILL_LD : DRAIN_LD;
            ENT_S:   timer_seconds = ENTRY_LD;
            XF_S:    timer_seconds = (grant_r == SIDE_HI) ? DRAIN_LD : FILL_LD;
            default: timer_seconds = 10'd0;
        endcase

        // The exit gate is always on the side opposite the one served.
        gate_lo_open = (in_ent && grant_r == SIDE_LO) || (state == EXIT && grant_r == SIDE_HI);
        gate_hi_open = (in_ent && grant_r == SIDE_HI) || (state == EXIT && grant_r == SIDE_LO);
        fill_valve   = (in_eq && grant_r == SIDE_HI) || (in_xf && grant_r == SIDE_LO);
        drain_valve  = (in_eq && grant_r == SIDE_LO) || (in_xf && grant_r == SIDE_HI);
        grant_hi     = grant_r;
        busy         = (state != IDLE);
    end

`ifdef LOCK_TRANSIT_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            transit_count <= 16'd0;
        end else if (state == EXIT && boat_out && transit_count != 16'hFFFF) begin
            transit_count <= transit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lock_transit_scheduler.sv
// tb/tb_lock_transit_scheduler.sv - directed self-checking bench for lock_transit_scheduler
module tb_lock_transit_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_lo = 1'b0;
    logic       req_hi = 1'b0;
    logic       boat_in = 1'b0;
    logic       boat_out = 1'b0;
    logic       timer_done;
    logic       timer_start;
    logic [9:0] timer_seconds;
    logic       gate_lo_open;
    logic       gate_hi_open;
    logic       fill_valve;
    logic       drain_valve;
    logic       grant_hi;
    logic       busy;
`ifdef LOCK_TRANSIT_COUNT_EN
    logic [15:0] transit_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam int P_START = 0;
    localparam int P_GLO   = 1;
    localparam int P_GHI   = 2;
    localparam int P_FILL  = 3;
    localparam int P_DRAIN = 4;

    always #5 clk = ~clk;

    lock_transit_scheduler #(
        .FILL_SEC  (3),
        .DRAIN_SEC (4),
        .ENTRY_SEC (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_lo        (req_lo),
        .req_hi        (req_hi),
        .boat_in       (boat_in),
        .boat_out      (boat_out),
        .timer_done    (timer_done),
        .timer_start   (timer_start),
        .timer_seconds (timer_seconds),
        .gate_lo_open  (gate_lo_open),
        .gate_hi_open  (gate_hi_open),
        .fill_valve    (fill_valve),
        .drain_valve   (drain_valve),
        .grant_hi      (grant_hi),
`ifdef LOCK_TRANSIT_COUNT_EN
        .transit_count (transit_count),
`endif
        .busy          (busy)
    );

    // Countdown model whose done flag lags the count by a cycle, so it is stale right after a load.
    logic [9:0] cnt;
    logic       done_q;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 10'd0;
            done_q <= 1'b1;
        end else begin
            if (timer_start) cnt <= timer_seconds;
            else if (cnt != 10'd0) cnt <= cnt - 10'd1;
            done_q <= (cnt == 10'd0);
        end
    end
    assign timer_done = done_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            P_START: return timer_start;
            P_GLO:   return gate_lo_open;
            P_GHI:   return gate_hi_open;
            P_FILL:  return fill_valve;
            P_DRAIN: return drain_valve;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!probe(which) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(probe(which)), 32'd1);
    endtask

    task automatic measure(input int which, input string tag, input int exp);
        int n = 0;
        while (probe(which) && n < 40) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic pulse_in(input int which);
        case (which)
            0: req_lo = 1'b1;
            1: req_hi = 1'b1;
            2: boat_in = 1'b1;
            default: boat_out = 1'b1;
        endcase
        @(negedge clk);
        req_lo = 1'b0;
        req_hi = 1'b0;
        boat_in = 1'b0;
        boat_out = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("exclusive",
                  {29'd0, gate_lo_open & gate_hi_open,
                   (gate_lo_open | gate_hi_open) & (fill_valve | drain_valve),
                   fill_valve & drain_valve}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_outputs", {timer_start, timer_seconds, gate_lo_open, gate_hi_open,
                              fill_valve, drain_valve, grant_hi, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Low transit from unknown level: equalise by draining first.
        pulse_in(0);
        wait_for(P_START, "s1_eq_start");
        check("s1_eq_secs", timer_seconds, 4);
        check("s1_eq_valves", {fill_valve, drain_valve}, 2'b01);
        check("s1_grant", {busy, grant_hi}, 2'b10);
        measure(P_DRAIN, "s1_eq_len", 7);
        check("s1_ent", {gate_lo_open, gate_hi_open, timer_start}, 3'b101);
        check("s1_ent_secs", timer_seconds, 2);
        @(negedge clk);
        pulse_in(2);
        check("s1_xf", {gate_lo_open, gate_hi_open, fill_valve, drain_valve, timer_start}, 5'b00101);
        check("s1_xf_secs", timer_seconds, 3);
        measure(P_FILL, "s1_xf_len", 6);
        check("s1_exit_gate", {gate_lo_open, gate_hi_open}, 2'b01);
        repeat (3) @(negedge clk);
        check("s1_exit_hold", {busy, gate_hi_open, timer_start}, 3'b110);
        pulse_in(3);
        check("s1_done", busy, 0);

        // High transit with level already high: straight to entry.
        pulse_in(1);
        wait_for(P_START, "s2_start");
        check("s2_no_eq", {gate_lo_open, gate_hi_open, fill_valve, drain_valve}, 4'b0100);
        check("s2_ent_secs", timer_seconds, 2);
        check("s2_grant", grant_hi, 1);
        @(negedge clk);
        pulse_in(2);
        check("s2_xf_drain", {fill_valve, drain_valve}, 2'b01);
        check("s2_xf_secs", timer_seconds, 4);
        measure(P_DRAIN, "s2_xf_len", 7);
        check("s2_exit_gate", {gate_lo_open, gate_hi_open}, 2'b10);
        pulse_in(3);
        check("s2_done", busy, 0);

        // Entry timeout: no boat arrives, transit dropped.
        pulse_in(0);
        wait_for(P_START, "to_start");
        check("to_ent", {gate_lo_open, gate_hi_open, fill_valve, drain_valve}, 4'b1000);
        check("to_secs", timer_seconds, 2);
        measure(P_GLO, "to_gate_len", 5);
        check("to_idle", {busy, gate_lo_open, gate_hi_open, fill_valve, drain_valve, timer_start}, 0);
        pulse_in(2);
        repeat (2) @(negedge clk);
        check("to_stay_idle", {busy, fill_valve, drain_valve, timer_start}, 0);

        // Simultaneous requests after a low grant: high first, low queued.
        req_lo = 1'b1;
        req_hi = 1'b1;
        @(negedge clk);
        req_lo = 1'b0;
        req_hi = 1'b0;
        wait_for(P_START, "s3_start");
        check("s3_grant", grant_hi, 1);
        check("s3_eq_fill", {fill_valve, drain_valve}, 2'b10);
        check("s3_eq_secs", timer_seconds, 3);
        measure(P_FILL, "s3_eq_len", 6);
        check("s3_ent", {gate_lo_open, gate_hi_open}, 2'b01);
        @(negedge clk);
        pulse_in(2);
        check("s3_xf_secs", timer_seconds, 4);
        measure(P_DRAIN, "s3_xf_len", 7);
        check("s3_exit", {gate_lo_open, gate_hi_open}, 2'b10);
        pulse_in(3);
        check("s3_done", busy, 0);
        @(negedge clk);
        check("s3_lo_next", {busy, grant_hi, gate_lo_open, timer_start}, 4'b1011);
        check("s3_lo_secs", timer_seconds, 2);
`ifdef LOCK_TRANSIT_COUNT_EN
        check("count_three", transit_count, 3);
`endif

        // Asynchronous reset in the middle of the transfer wait.
        @(negedge clk);
        pulse_in(2);
        check("rx_xf_fill", {fill_valve, timer_start}, 2'b11);
        check("rx_xf_secs", timer_seconds, 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rx_async_zero", {timer_start, timer_seconds, gate_lo_open, gate_hi_open,
                                fill_valve, drain_valve, grant_hi, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`ifdef LOCK_TRANSIT_COUNT_EN
        check("count_reset", transit_count, 0);
`endif
        pulse_in(0);
        wait_for(P_START, "rx_eq_start");
        check("rx_eq_drain", {fill_valve, drain_valve}, 2'b01);
        check("rx_eq_secs", timer_seconds, 4);
        measure(P_DRAIN, "rx_eq_len", 7);
        check("rx_ent", gate_lo_open, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
